// File: rtl/primus_instruction_decode.sv
// RV32I decode stage: field/immediate extraction, owned 32x32 register file, one registered packet toward execute.
// Optional PRIMUS_DECODE_ILLEGAL_EN adds illegal_o and strict funct-field checking.
module primus_instruction_decode #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [31:0]     ir_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            flush_i,
    input  logic            wb_en_i,
    input  logic [4:0]      wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] pc_o,
    output logic [3:0]      op_class_o,
    output logic [2:0]      funct3_o,
    output logic            funct7b5_o,
    output logic [4:0]      rd_o,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic [XLEN-1:0] rs1_data_o,
    output logic [XLEN-1:0] rs2_data_o,
`ifdef PRIMUS_DECODE_ILLEGAL_EN
    output logic            illegal_o,
`endif
    output logic [XLEN-1:0] imm_o
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [3:0] CLS_LUI    = 4'd0;
    localparam logic [3:0] CLS_AUIPC  = 4'd1;
    localparam logic [3:0] CLS_JAL    = 4'd2;
    localparam logic [3:0] CLS_JALR   = 4'd3;
    localparam logic [3:0] CLS_BRANCH = 4'd4;
    localparam logic [3:0] CLS_LOAD   = 4'd5;
    localparam logic [3:0] CLS_STORE  = 4'd6;
    localparam logic [3:0] CLS_OP_IMM = 4'd7;
    localparam logic [3:0] CLS_OP     = 4'd8;
    localparam logic [3:0] CLS_FENCE  = 4'd9;
    localparam logic [3:0] CLS_SYSTEM = 4'd10;

    logic [XLEN-1:0] regs [NREGS];
    logic            accept;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic            recog;
    logic [3:0]      dec_class;
    logic [4:0]      dec_rd;
    logic [2:0]      dec_f3;
    logic [XLEN-1:0] dec_imm;

    assign ready_o = !rst_i && (!valid_o || ready_i);
    assign accept  = valid_i && ready_o && !flush_i;

    assign opcode = ir_i[6:0];
    assign funct3 = ir_i[14:12];
    assign rs1    = ir_i[19:15];
    assign rs2    = ir_i[24:20];

    assign imm_i = {{20{ir_i[31]}}, ir_i[31:20]};
    assign imm_s = {{20{ir_i[31]}}, ir_i[31:25], ir_i[11:7]};
    assign imm_b = {{19{ir_i[31]}}, ir_i[31], ir_i[7], ir_i[30:25], ir_i[11:8], 1'b0};
    assign imm_u = {ir_i[31:12], 12'h000};
    assign imm_j = {{11{ir_i[31]}}, ir_i[31], ir_i[19:12], ir_i[20], ir_i[30:21], 1'b0};

    // Operand read with same-cycle writeback bypass; x0 always reads zero.
    assign rs1_val = (rs1 == 5'd0) ? '0 :
                     (wb_en_i && (wb_rd_i == rs1)) ? wb_data_i : regs[rs1];
    assign rs2_val = (rs2 == 5'd0) ? '0 :
                     (wb_en_i && (wb_rd_i == rs2)) ? wb_data_i : regs[rs2];

    always_comb begin
        recog = 1'b1;
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
            OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_FENCE, OPC_SYSTEM: recog = 1'b1;
            default: recog = 1'b0;
        endcase
    end

`ifdef PRIMUS_DECODE_ILLEGAL_EN
    localparam logic [3:0] CLS_ILLEGAL = 4'd15;
    logic [6:0] funct7;
    logic       bad_funct;
    logic       illegal_c;

    assign funct7 = ir_i[31:25];

    // Reserved funct encodings within otherwise recognised opcodes.
    always_comb begin
        bad_funct = 1'b0;
        case (opcode)
            OPC_JALR:   bad_funct = (funct3 != 3'b000);
            OPC_LOAD:   bad_funct = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            OPC_STORE:  bad_funct = (funct3 >= 3'b011);
            OPC_BRANCH: bad_funct = (funct3 == 3'b010) || (funct3 == 3'b011);
            OPC_OP:     bad_funct = !((funct7 == 7'b0000000) ||
                                      ((funct7 == 7'b0100000) &&
                                       ((funct3 == 3'b000) || (funct3 == 3'b101))));
            OPC_OP_IMM: bad_funct = ((funct3 == 3'b001) && (funct7 != 7'b0000000)) ||
                                    ((funct3 == 3'b101) && (funct7 != 7'b0000000) &&
                                     (funct7 != 7'b0100000));
            default:    bad_funct = 1'b0;
        endcase
    end

    assign illegal_c = !recog || bad_funct;
`endif

    always_comb begin
        dec_class = CLS_OP_IMM;
        dec_rd    = ir_i[11:7];
        dec_f3    = funct3;
        dec_imm   = '0;
        case (opcode)
            OPC_LUI:    begin dec_class = CLS_LUI;    dec_imm = imm_u; end
            OPC_AUIPC:  begin dec_class = CLS_AUIPC;  dec_imm = imm_u; end
            OPC_JAL:    begin dec_class = CLS_JAL;    dec_imm = imm_j; end
            OPC_JALR:   begin dec_class = CLS_JALR;   dec_imm = imm_i; end
            OPC_BRANCH: begin dec_class = CLS_BRANCH; dec_imm = imm_b; dec_rd = 5'd0; end
            OPC_LOAD:   begin dec_class = CLS_LOAD;   dec_imm = imm_i; end
            OPC_STORE:  begin dec_class = CLS_STORE;  dec_imm = imm_s; dec_rd = 5'd0; end
            OPC_OP_IMM: begin dec_class = CLS_OP_IMM; dec_imm = imm_i; end
            OPC_OP:     begin dec_class = CLS_OP; end
            OPC_FENCE:  begin dec_class = CLS_FENCE;  dec_rd = 5'd0; end
            OPC_SYSTEM: begin dec_class = CLS_SYSTEM; dec_imm = imm_i; end
            default:    begin dec_class = CLS_OP_IMM; end
        endcase
`ifdef PRIMUS_DECODE_ILLEGAL_EN
        if (illegal_c) begin
            dec_class = CLS_ILLEGAL;
            dec_rd    = 5'd0;
            dec_imm   = '0;
        end
`else
        // Unrecognised opcodes become a NOP (addi x0, x0, 0 shaped).
        if (!recog) begin
            dec_class = CLS_OP_IMM;
            dec_rd    = 5'd0;
            dec_f3    = 3'b000;
            dec_imm   = '0;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o    <= 1'b0;
            pc_o       <= '0;
            op_class_o <= '0;
            funct3_o   <= '0;
            funct7b5_o <= 1'b0;
            rd_o       <= '0;
            rs1_o      <= '0;
            rs2_o      <= '0;
            rs1_data_o <= '0;
            rs2_data_o <= '0;
            imm_o      <= '0;
`ifdef PRIMUS_DECODE_ILLEGAL_EN
            illegal_o  <= 1'b0;
`endif
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            if (wb_en_i && (wb_rd_i != 5'd0)) regs[wb_rd_i] <= wb_data_i;
            if (flush_i) begin
                valid_o <= 1'b0;
            end else if (accept) begin
                valid_o    <= 1'b1;
                pc_o       <= pc_i;
                op_class_o <= dec_class;
                funct3_o   <= dec_f3;
                funct7b5_o <= ir_i[30];
                rd_o       <= dec_rd;
                rs1_o      <= rs1;
                rs2_o      <= rs2;
                rs1_data_o <= rs1_val;
                rs2_data_o <= rs2_val;
                imm_o      <= dec_imm;
`ifdef PRIMUS_DECODE_ILLEGAL_EN
                illegal_o  <= illegal_c;
`endif
            end else if (ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end
endmodule
